// File: rtl/less_distance_circuit.sv
// Nearest-to-reference selector: registers whichever of dataA/dataB lies closer to reff.
// Built from bit-slice ripple subtractors and a ripple magnitude comparator; ties pick dataB.
module less_distance_circuit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dataA,
  input  logic [7:0] dataB,
  input  logic [7:0] reff,
  output logic [7:0] answer
);

  // Full-subtractor chain, LSB first. Bit 8 of the result is the final borrow.
  function automatic logic [8:0] ripple_sub(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] diff;
    logic       bor;
    bor  = 1'b0;
    diff = '0;
    for (int i = 0; i < 8; i++) begin
      diff[i] = x[i] ^ y[i] ^ bor;
      bor     = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bor);
    end
    return {bor, diff};
  endfunction

  // A borrow out of x - y means x < y, so the magnitude comes from a second chain y - x.
  function automatic logic [7:0] abs_dist(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] fwd;
    logic [8:0] rev;
    fwd = ripple_sub(x, y);
    rev = ripple_sub(y, x);
    return fwd[8] ? rev[7:0] : fwd[7:0];
  endfunction

  // Magnitude comparator rippling from MSB down: x > y.
  function automatic logic ripple_gt(input logic [7:0] x, input logic [7:0] y);
    logic gt;
    logic eq;
    gt = 1'b0;
    eq = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      gt = gt | (eq & x[i] & ~y[i]);
      eq = eq & ~(x[i] ^ y[i]);
    end
    return gt;
  endfunction

  logic [7:0] w_dist_a;
  logic [7:0] w_dist_b;
  logic       w_gt;
  logic [7:0] w_next;
  logic [7:0] r_answer;

  always_comb begin
    w_dist_a = abs_dist(dataA, reff);
    w_dist_b = abs_dist(dataB, reff);
    w_gt     = ripple_gt(w_dist_b, w_dist_a);
    w_next   = w_gt ? dataA : dataB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_answer <= 8'h00;
    else        r_answer <= w_next;
  end

  assign answer = r_answer;

endmodule

// File: tb/tb_less_distance_circuit.sv
// Scoreboard bench for less_distance_circuit: the driver queues expected winners,
// an independent monitor pops and compares one entry per clock edge.
module tb_less_distance_circuit;

  logic       clk;
  logic       rst_n;
  logic [7:0] dataA;
  logic [7:0] dataB;
  logic [7:0] reff;
  logic [7:0] answer;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [7:0] exp;
  } item_t;

  item_t sb_q[$];

  less_distance_circuit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dataA  (dataA),
    .dataB  (dataB),
    .reff   (reff),
    .answer (answer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
    int da;
    int db;
    da = (int'(a) > int'(r)) ? int'(a) - int'(r) : int'(r) - int'(a);
    db = (int'(b) > int'(r)) ? int'(b) - int'(r) : int'(r) - int'(a == a ? b : b);
    return (db > da) ? a : b;
  endfunction

  // Drive on the falling edge so the next rising edge captures the vector.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                       input logic [7:0] exp);
    item_t it;
    @(negedge clk);
    dataA = a;
    dataB = b;
    reff  = r;
    it.a = a; it.b = b; it.r = r; it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic check_now(input string name, input logic [7:0] exp);
    vectors++;
    if (answer !== exp) begin
      miscompares++;
      $display("FAIL %s: answer=%0d expected=%0d", name, answer, exp);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (sb_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: pending=%0d expected=0", sb_q.size());
    end
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        vectors++;
        if (answer !== it.exp) begin
          miscompares++;
          $display("FAIL sb a=%0d b=%0d r=%0d: answer=%0d expected=%0d",
                   it.a, it.b, it.r, answer, it.exp);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rr;

    rst_n = 1'b0;
    dataA = 8'hA5;
    dataB = 8'h3C;
    reff  = 8'h77;
    #2;
    check_now("reset_idle", 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_now("reset_release_hold", 8'h00);

    apply(8'd12,  8'd3,   8'd10,  8'd12);
    apply(8'd90,  8'd120, 8'd100, 8'd90);
    apply(8'd120, 8'd90,  8'd100, 8'd90);
    apply(8'd0,   8'd100, 8'd50,  8'd100);
    apply(8'd100, 8'd0,   8'd50,  8'd0);
    apply(8'd255, 8'd1,   8'd0,   8'd1);
    apply(8'd0,   8'd255, 8'd255, 8'd255);
    apply(8'd127, 8'd129, 8'd128, 8'd129);
    apply(8'h7F,  8'h80,  8'h80,  8'h80);
    apply(8'h80,  8'h7F,  8'h80,  8'h80);
    apply(8'd0,   8'd200, 8'd201, 8'd200);
    apply(8'd77,  8'd77,  8'd3,   8'd77);
    drain();

    // Asynchronous reset between edges clears the output without a clock.
    apply(8'd40, 8'd200, 8'd45, 8'd40);
    drain();
    #1;
    rst_n = 1'b0;
    #1;
    check_now("reset_midop", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rr = 8'($urandom_range(0, 255));
      apply(ra, rb, rr, model(ra, rb, rr));
    end
    drain();

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        rr = 8'($urandom_range(0, 255));
        apply(8'(a), 8'(b), rr, model(8'(a), 8'(b), rr));
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
